// File: rtl/rx_ram_arb_pkg.sv
// rx_ram_arb shared types: arbiter FSM state and grant indices.
// Imported by rx_ram_arb.
package rx_ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/rx_ram_arb.sv
// Round-robin arbiter for one RX packet buffer RAM: m0 writer, m1 reader.
// Define RX_RAM_ARB_STATS_EN to add accepted write/read counters.
module rx_ram_arb
  import rx_ram_arb_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk_original,
  input  logic            rst_n,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  output logic            m0_waitrequest,
  input  logic            m0_pkt_done,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_read,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_readdatavalid,
  input  logic            m1_pkt_release,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_chipselect,
  output logic            ram_write,
  output logic            ram_read,
  output logic [DW-1:0]   ram_writedata,
  output logic [DW/8-1:0] ram_byteenable,
  input  logic [DW-1:0]   ram_readdata,
  input  logic            ram_waitrequest,
`ifdef RX_RAM_ARB_STATS_EN
  output logic [15:0]     stat_wr_cnt,
  output logic [15:0]     stat_rd_cnt,
`endif
  output logic            buf_full
);

  localparam int BW = DW / 8;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_gnt;
  logic            r_buf_full;
  logic            w_m0_elig;
  logic            w_m1_elig;
  logic            w_pick_m1;
  logic            w_acc;
  logic            w_start0;
  logic            w_start1;

  logic [AW-1:0]   r_addr;
  logic            r_cs;
  logic            r_wr;
  logic            r_rd;
  logic [DW-1:0]   r_wdata;
  logic [BW-1:0]   r_be;
  logic            r_rdv;
  logic [DW-1:0]   r_rdata;

  // Eligibility, round-robin pick and next state.
  always_comb begin
    w_m0_elig = m0_write && !r_buf_full;
    w_m1_elig = m1_read;
    w_pick_m1 = w_m1_elig &&
                (!w_m0_elig || (r_last_gnt == GNT_M0));
    w_acc     = (r_state != IDLE) && !ram_waitrequest;
    w_next    = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_m0_elig || w_m1_elig)
          w_next = w_pick_m1 ? GNT1 : GNT0;
      end
      GNT0, GNT1: begin
        if (!ram_waitrequest)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    w_start0 = (r_state == IDLE) && (w_next == GNT0);
    w_start1 = (r_state == IDLE) && (w_next == GNT1);
  end

  // FSM state register.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Remember the last accepted master for round-robin.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n)
      r_last_gnt <= GNT_M1;
    else if (w_acc)
      r_last_gnt <= (r_state == GNT1) ? GNT_M1 : GNT_M0;
  end

  // Packet lock: a new packet wins over a same-cycle release.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n)              r_buf_full <= 1'b0;
    else if (m0_pkt_done)    r_buf_full <= 1'b1;
    else if (m1_pkt_release) r_buf_full <= 1'b0;
  end

  // RAM command latched at grant, held through stalls, dropped on accept.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_start0) begin
      r_addr  <= m0_addr;
      r_cs    <= 1'b1;
      r_wr    <= 1'b1;
      r_rd    <= 1'b0;
      r_wdata <= m0_writedata;
      r_be    <= m0_byteenable;
    end else if (w_start1) begin
      r_addr  <= m1_addr;
      r_cs    <= 1'b1;
      r_wr    <= 1'b0;
      r_rd    <= 1'b1;
      r_be    <= '1;
    end else if (w_acc) begin
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
    end
  end

  // Read-valid one cycle after an accepted m1 read.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) r_rdv <= 1'b0;
    else        r_rdv <= w_acc && (r_state == GNT1);
  end

  // Keep the last returned word visible once valid drops.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n)     r_rdata <= '0;
    else if (r_rdv) r_rdata <= ram_readdata;
  end

`ifdef RX_RAM_ARB_STATS_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;

  // Accepted-access counters, free-running wrap.
  always_ff @(posedge clk_original or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (w_acc) begin
      if (r_state == GNT0) r_wr_cnt <= r_wr_cnt + 16'd1;
      else                 r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  assign stat_wr_cnt = r_wr_cnt;
  assign stat_rd_cnt = r_rd_cnt;
`endif

  assign m0_waitrequest   = !((r_state == GNT0) && !ram_waitrequest);
  assign m1_readdatavalid = r_rdv;
  assign m1_readdata      = r_rdv ? ram_readdata : r_rdata;
  assign ram_addr         = r_addr;
  assign ram_chipselect   = r_cs;
  assign ram_write        = r_wr;
  assign ram_read         = r_rd;
  assign ram_writedata    = r_wdata;
  assign ram_byteenable   = r_be;
  assign buf_full         = r_buf_full;

endmodule

// File: tb/tb_rx_ram_arb.sv
// Scoreboard bench for rx_ram_arb: directed stimulus, queued expectations,
// negedge monitor comparing every accepted RAM access and every read return.
module tb_rx_ram_arb;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk_original = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   m0_addr;
  logic            m0_write;
  logic [DW-1:0]   m0_writedata;
  logic [BW-1:0]   m0_byteenable;
  logic            m0_waitrequest;
  logic            m0_pkt_done;
  logic [AW-1:0]   m1_addr;
  logic            m1_read;
  logic [DW-1:0]   m1_readdata;
  logic            m1_readdatavalid;
  logic            m1_pkt_release;
  logic [AW-1:0]   ram_addr;
  logic            ram_chipselect;
  logic            ram_write;
  logic            ram_read;
  logic [DW-1:0]   ram_writedata;
  logic [BW-1:0]   ram_byteenable;
  logic [DW-1:0]   ram_readdata = '0;
  logic            ram_waitrequest;
  logic            buf_full;
`ifdef RX_RAM_ARB_STATS_EN
  logic [15:0]     stat_wr_cnt;
  logic [15:0]     stat_rd_cnt;
`endif

  always #5 clk_original = ~clk_original;

  rx_ram_arb #(.AW(AW), .DW(DW)) dut (
    .clk_original     (clk_original),
    .rst_n            (rst_n),
    .m0_addr          (m0_addr),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_byteenable    (m0_byteenable),
    .m0_waitrequest   (m0_waitrequest),
    .m0_pkt_done      (m0_pkt_done),
    .m1_addr          (m1_addr),
    .m1_read          (m1_read),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_pkt_release   (m1_pkt_release),
    .ram_addr         (ram_addr),
    .ram_chipselect   (ram_chipselect),
    .ram_write        (ram_write),
    .ram_read         (ram_read),
    .ram_writedata    (ram_writedata),
    .ram_byteenable   (ram_byteenable),
    .ram_readdata     (ram_readdata),
    .ram_waitrequest  (ram_waitrequest),
`ifdef RX_RAM_ARB_STATS_EN
    .stat_wr_cnt      (stat_wr_cnt),
    .stat_rd_cnt      (stat_rd_cnt),
`endif
    .buf_full         (buf_full)
  );

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } acc_t;

  acc_t          exp_acc[$];
  logic [DW-1:0] exp_rd[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_acc = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic acc_t mk_wr(input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
    acc_t t;
    t.wr = 1'b1; t.rd = 1'b0; t.addr = a;
    t.data = d; t.be = '1;
    return t;
  endfunction

  function automatic acc_t mk_rd(input logic [AW-1:0] a);
    acc_t t;
    t.wr = 1'b0; t.rd = 1'b1; t.addr = a;
    t.data = '0; t.be = '0;
    return t;
  endfunction

  // RAM model: one-cycle read latency after acceptance.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk_original) begin
    if (ram_chipselect && !ram_waitrequest) begin
      if (ram_write)
        for (int b = 0; b < BW; b++)
          if (ram_byteenable[b])
            mem[ram_addr][8*b +: 8] <= ram_writedata[8*b +: 8];
      if (ram_read)
        ram_readdata <= mem[ram_addr];
    end
  end

  // Monitor: pop and compare on every accepted access and read return.
  always @(negedge clk_original) begin : mon
    acc_t a;
    acc_t e;
    logic [DW-1:0] ed;
    if (rst_n === 1'b1) begin
      if (ram_chipselect && !ram_waitrequest) begin
        n_acc++;
        a.wr   = ram_write;
        a.rd   = ram_read;
        a.addr = ram_addr;
        a.data = ram_write ? ram_writedata : '0;
        a.be   = ram_write ? ram_byteenable : '0;
        if (exp_acc.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_access: got %h expected none", a);
        end else begin
          e = exp_acc.pop_front();
          chk("ram_access", 64'(a), 64'(e));
        end
      end
      if (m1_readdatavalid) begin
        if (exp_rd.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rdv: got %h expected none", m1_readdata);
        end else begin
          ed = exp_rd.pop_front();
          chk("readdata", 64'(m1_readdata), 64'(ed));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_original);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_m0_wait"}, 64'(m0_waitrequest), 64'd1);
    chk({nm, "_ram"}, 64'({ram_addr, ram_chipselect, ram_write,
                           ram_read, ram_byteenable}), 64'd0);
    chk({nm, "_ram_wd"}, 64'(ram_writedata), 64'd0);
    chk({nm, "_rd"}, 64'({m1_readdatavalid, m1_readdata}), 64'd0);
    chk({nm, "_buf_full"}, 64'(buf_full), 64'd0);
  endtask

  task automatic m0_wr(input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       output int lat);
    exp_acc.push_back(mk_wr(a, d));
    m0_addr = a; m0_writedata = d;
    m0_byteenable = '1; m0_write = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk_original);
      if (!m0_waitrequest) break;
      lat++;
      if (lat > 50) begin
        n_cmp++; n_err++;
        $display("FAIL wr_timeout: got no accept expected accept");
        break;
      end
    end
    tick();
    m0_write = 1'b0;
  endtask

  task automatic m1_rd(input logic [AW-1:0] a,
                       input logic [DW-1:0] d,
                       output int lat);
    exp_acc.push_back(mk_rd(a));
    exp_rd.push_back(d);
    m1_addr = a; m1_read = 1'b1;
    lat = 0;
    while (1) begin
      @(negedge clk_original);
      if (ram_chipselect && ram_read && !ram_waitrequest) break;
      lat++;
      if (lat > 50) begin
        n_cmp++; n_err++;
        $display("FAIL rd_timeout: got no accept expected accept");
        break;
      end
    end
    tick();
    m1_read = 1'b0;
    @(negedge clk_original);
    chk("rdv_one_cycle", 64'(m1_readdatavalid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int seen;
    int got;
    rst_n = 1'b0;
    m0_addr = '0; m0_write = 1'b0; m0_writedata = '0;
    m0_byteenable = '0; m0_pkt_done = 1'b0;
    m1_addr = '0; m1_read = 1'b0; m1_pkt_release = 1'b0;
    ram_waitrequest = 1'b0;
    mem[10'h020] = 32'hCAFE_0020;
    mem[10'h3FF] = 32'h1234_5678;
    repeat (3) tick();
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // Single write, no stall: accepted on the first grant cycle.
    m0_wr(10'h005, 32'hDEAD_BEEF, lat);
    chk("wr_latency", 64'(lat), 64'd1);
    m1_rd(10'h005, 32'hDEAD_BEEF, lat);
    chk("rd_latency_a", 64'(lat), 64'd1);
    tick();
    m1_rd(10'h3FF, 32'h1234_5678, lat);
    chk("rd_latency_b", 64'(lat), 64'd1);
`ifdef RX_RAM_ARB_STATS_EN
    chk("stat_wr", 64'(stat_wr_cnt), 64'd1);
    chk("stat_rd", 64'(stat_rd_cnt), 64'd2);
`endif
    tick();

    // Conflict from reset: m0, m1, m0, m1 in 8 cycles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_acc.push_back(mk_wr(10'h010, 32'hA5A5_0010));
    exp_acc.push_back(mk_rd(10'h020));
    exp_acc.push_back(mk_wr(10'h010, 32'hA5A5_0010));
    exp_acc.push_back(mk_rd(10'h020));
    exp_rd.push_back(32'hCAFE_0020);
    exp_rd.push_back(32'hCAFE_0020);
    base = n_acc;
    m0_addr = 10'h010; m0_writedata = 32'hA5A5_0010;
    m0_byteenable = '1; m0_write = 1'b1;
    m1_addr = 10'h020; m1_read = 1'b1;
    repeat (8) @(negedge clk_original);
    #1;
    chk("conflict_4_in_8", 64'(n_acc - base), 64'd4);
    tick();
    m0_write = 1'b0; m1_read = 1'b0;
    repeat (2) tick();

    // Buffer lock: m0 stalls until release.
    m0_pkt_done = 1'b1;
    tick();
    m0_pkt_done = 1'b0;
    chk("buf_full_set", 64'(buf_full), 64'd1);
    exp_acc.push_back(mk_wr(10'h040, 32'h0BAD_F00D));
    m0_addr = 10'h040; m0_writedata = 32'h0BAD_F00D;
    m0_byteenable = '1; m0_write = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk_original);
      if (!m0_waitrequest || ram_chipselect) seen++;
    end
    chk("lock_stall", 64'(seen), 64'd0);
    tick();
    m1_pkt_release = 1'b1;
    lat = 0; got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      @(negedge clk_original);
      if (!m0_waitrequest) got = 1;
      else lat++;
      if (i == 0) begin
        @(posedge clk_original); #1;
        m1_pkt_release = 1'b0;
      end
    end
    chk("unlock_within_2", 64'(lat <= 2 && got == 1), 64'd1);
    tick();
    m0_write = 1'b0;
    chk("buf_released", 64'(buf_full), 64'd0);
    m0_pkt_done = 1'b1; m1_pkt_release = 1'b1;
    tick();
    m0_pkt_done = 1'b0; m1_pkt_release = 1'b0;
    chk("done_and_release", 64'(buf_full), 64'd1);
    m1_pkt_release = 1'b1;
    tick();
    m1_pkt_release = 1'b0;
    chk("release_only", 64'(buf_full), 64'd0);
    tick();

    // Stalled m1 grant, then reset in the third stall cycle.
    ram_waitrequest = 1'b1;
    m1_addr = 10'h0AB; m1_read = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_original);
      chk("stall_addr", 64'(ram_addr), 64'h0AB);
      chk("stall_rd", 64'({ram_chipselect, ram_read}), 64'h3);
      tick();
    end
    rst_n = 1'b0;
    m1_read = 1'b0;
    #1;
    chk_reset("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ram_waitrequest = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk_original);
      if (m1_readdatavalid) seen++;
    end
    chk("no_rdv_after_reset", 64'(seen), 64'd0);
    tick();

    chk("acc_queue_empty", 64'(exp_acc.size()), 64'd0);
    chk("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
